// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame counter: controller state encoding.
package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_DONE  = 2'd2
   } spi_state_t;

endpackage : spi_pkg

// File: rtl/spi_frame_counter.sv
// Bit/word/frame position counter for an SPI engine. Tracks the next bit within the word
// and the current word within the frame, with per-word and per-frame completion pulses.
module spi_frame_counter
   import spi_pkg::*;
#(
   parameter int MaxWordLen = 32,
   parameter int MaxWords   = 16,
   localparam int BW        = $clog2(MaxWordLen),
   localparam int WW        = (MaxWords > 1) ? $clog2(MaxWords) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          EnCount,
   input  logic          SampleEdge,
   input  logic          Continuous,
   input  logic [BW-1:0] WordLenM1,
   input  logic [WW-1:0] FrameLenM1,
   output logic [BW-1:0] BitIdx,
   output logic [WW-1:0] WordIdx,
   output logic          LastBit,
   output logic          WordFlg,
   output logic          FrameFlg,
   output logic          Busy
);

   localparam logic [BW-1:0] WLEN_MAX = BW'(MaxWordLen - 1);
   localparam logic [WW-1:0] FLEN_MAX = WW'(MaxWords - 1);

   spi_state_t    r_state;
   logic [BW-1:0] r_bit_idx;
   logic [WW-1:0] r_word_idx;
   logic [BW-1:0] r_wlen;
   logic [WW-1:0] r_flen;
   logic          r_word_flg;
   logic          r_frame_flg;
   logic          r_busy;

   logic [BW-1:0] w_wlen_clamp;
   logic [WW-1:0] w_flen_clamp;

   // Out-of-range lengths saturate to the largest supported size when latched.
   assign w_wlen_clamp = (WordLenM1  > WLEN_MAX) ? WLEN_MAX : WordLenM1;
   assign w_flen_clamp = (FrameLenM1 > FLEN_MAX) ? FLEN_MAX : FrameLenM1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_bit_idx   <= '0;
         r_word_idx  <= '0;
         r_wlen      <= '0;
         r_flen      <= '0;
         r_word_flg  <= 1'b0;
         r_frame_flg <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_word_flg  <= 1'b0;
         r_frame_flg <= 1'b0;
         if (!EnCount) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_bit_idx  <= '0;
            r_word_idx <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  // A strobe coinciding with the entry edge is deliberately not counted.
                  r_state    <= ST_COUNT;
                  r_busy     <= 1'b1;
                  r_bit_idx  <= '0;
                  r_word_idx <= '0;
                  r_wlen     <= w_wlen_clamp;
                  r_flen     <= w_flen_clamp;
               end
               ST_COUNT: begin
                  if (SampleEdge) begin
                     if (r_bit_idx == r_wlen) begin
                        r_bit_idx  <= '0;
                        r_word_flg <= 1'b1;
                        if (r_word_idx == r_flen) begin
                           r_word_idx  <= '0;
                           r_frame_flg <= 1'b1;
                           if (Continuous) begin
                              r_wlen <= w_wlen_clamp;
                              r_flen <= w_flen_clamp;
                           end else begin
                              r_state <= ST_DONE;
                              r_busy  <= 1'b0;
                           end
                        end else begin
                           r_word_idx <= r_word_idx + WW'(1);
                        end
                     end else begin
                        r_bit_idx <= r_bit_idx + BW'(1);
                     end
                  end
               end
               ST_DONE: begin
                  r_bit_idx  <= '0;
                  r_word_idx <= '0;
               end
               default: begin
                  r_state    <= ST_IDLE;
                  r_busy     <= 1'b0;
                  r_bit_idx  <= '0;
                  r_word_idx <= '0;
               end
            endcase
         end
      end
   end

   assign BitIdx   = r_bit_idx;
   assign WordIdx  = r_word_idx;
   assign WordFlg  = r_word_flg;
   assign FrameFlg = r_frame_flg;
   assign Busy     = r_busy;
   assign LastBit  = (r_state == ST_COUNT) && (r_bit_idx == r_wlen);

endmodule : spi_frame_counter

// File: tb/tb_spi_frame_counter.sv
// Directed self-checking bench for spi_frame_counter (MaxWordLen=20, MaxWords=12 to reach the clamps).
module tb_spi_frame_counter;

   localparam int MWL = 20;
   localparam int MWS = 12;
   localparam int BW  = $clog2(MWL);
   localparam int WW  = $clog2(MWS);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          EnCount;
   logic          SampleEdge;
   logic          Continuous;
   logic [BW-1:0] WordLenM1;
   logic [WW-1:0] FrameLenM1;
   logic [BW-1:0] BitIdx;
   logic [WW-1:0] WordIdx;
   logic          LastBit;
   logic          WordFlg;
   logic          FrameFlg;
   logic          Busy;

   int n_cmp = 0;
   int n_err = 0;

   spi_frame_counter #(.MaxWordLen(MWL), .MaxWords(MWS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .EnCount    (EnCount),
      .SampleEdge (SampleEdge),
      .Continuous (Continuous),
      .WordLenM1  (WordLenM1),
      .FrameLenM1 (FrameLenM1),
      .BitIdx     (BitIdx),
      .WordIdx    (WordIdx),
      .LastBit    (LastBit),
      .WordFlg    (WordFlg),
      .FrameFlg   (FrameFlg),
      .Busy       (Busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int wl, input int fl, input logic cont);
      EnCount    = 1'b0;
      SampleEdge = 1'b0;
      tick();
      WordLenM1  = BW'(wl);
      FrameLenM1 = WW'(fl);
      Continuous = cont;
      EnCount    = 1'b1;
      tick();
   endtask

   initial begin
      int wcnt;
      rst_n = 1'b0; EnCount = 1'b0; SampleEdge = 1'b0; Continuous = 1'b0;
      WordLenM1 = '0; FrameLenM1 = '0;
      #13;
      check("rst_busy", Busy, 0);
      check("rst_bit", BitIdx, 0);
      check("rst_word", WordIdx, 0);
      check("rst_wflg", WordFlg, 0);
      check("rst_fflg", FrameFlg, 0);
      check("rst_last", LastBit, 0);
      #4 rst_n = 1'b1;
      tick();
      check("idle_busy", Busy, 0);

      // Single 8-bit word, single-word frame, one-shot
      start(7, 0, 1'b0);
      check("t1_busy", Busy, 1);
      check("t1_bit0", BitIdx, 0);
      for (int i = 1; i <= 8; i++) begin
         if (i == 8) check("t1_last", LastBit, 1);
         SampleEdge = 1'b1; tick(); SampleEdge = 1'b0;
         check($sformatf("t1_wflg%0d", i), WordFlg, (i == 8));
         check($sformatf("t1_fflg%0d", i), FrameFlg, (i == 8));
      end
      check("t1_done_busy", Busy, 0);
      SampleEdge = 1'b1; tick(); SampleEdge = 1'b0;
      check("t1_done_bit", BitIdx, 0);
      check("t1_done_wflg", WordFlg, 0);
      check("t1_done_last", LastBit, 0);

      // 4-bit words, 3-word frames, continuous; entry-cycle strobe ignored
      EnCount = 1'b0; tick();
      WordLenM1 = BW'(3); FrameLenM1 = WW'(2); Continuous = 1'b1;
      EnCount = 1'b1; SampleEdge = 1'b1;
      tick();
      check("t2_entry_bit", BitIdx, 0);
      for (int i = 1; i <= 24; i++) begin
         tick();
         check($sformatf("t2_wflg%0d", i), WordFlg, (i % 4 == 0));
         check($sformatf("t2_fflg%0d", i), FrameFlg, (i % 12 == 0));
      end
      SampleEdge = 1'b0;
      check("t2_busy", Busy, 1);
      check("t2_word", WordIdx, 0);

      // Live WordLenM1 change only takes effect at the next frame
      start(7, 0, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         if (i == 4) WordLenM1 = BW'(3);
         SampleEdge = 1'b1; tick(); SampleEdge = 1'b0;
         check($sformatf("t3_wflg%0d", i), WordFlg, (i == 8));
      end
      for (int i = 1; i <= 4; i++) begin
         SampleEdge = 1'b1; tick(); SampleEdge = 1'b0;
         check($sformatf("t3_nwflg%0d", i), WordFlg, (i == 4));
      end

      // Abort mid-word, then restart from zero
      start(7, 0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         SampleEdge = 1'b1; tick(); SampleEdge = 1'b0;
      end
      check("t4_bit5", BitIdx, 5);
      EnCount = 1'b0; SampleEdge = 1'b1; tick(); SampleEdge = 1'b0;
      check("t4_abort_bit", BitIdx, 0);
      check("t4_abort_wflg", WordFlg, 0);
      check("t4_abort_busy", Busy, 0);
      EnCount = 1'b1; tick();
      SampleEdge = 1'b1; tick(); SampleEdge = 1'b0;
      check("t4_restart_bit", BitIdx, 1);
      for (int i = 2; i <= 8; i++) begin
         SampleEdge = 1'b1; tick(); SampleEdge = 1'b0;
         check($sformatf("t4_wflg%0d", i), WordFlg, (i == 8));
      end

      // Asynchronous reset between clock edges
      start(7, 0, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         SampleEdge = 1'b1; tick(); SampleEdge = 1'b0;
      end
      check("t5_bit3", BitIdx, 3);
      #2 rst_n = 1'b0;
      #1;
      check("t5_async_bit", BitIdx, 0);
      check("t5_async_busy", Busy, 0);
      #2 rst_n = 1'b1;
      tick();
      check("t5_resume_busy", Busy, 1);

      // 1-bit words, 2-word frames, strobe every cycle
      start(0, 1, 1'b1);
      check("t6_last0", LastBit, 1);
      SampleEdge = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         check($sformatf("t6_wflg%0d", i), WordFlg, 1);
         check($sformatf("t6_last%0d", i), LastBit, 1);
         check($sformatf("t6_fflg%0d", i), FrameFlg, (i % 2 == 0));
      end
      SampleEdge = 1'b0;

      // Out-of-range lengths clamp to 20-bit words, 12-word frames
      start(25, 15, 1'b0);
      wcnt = 0;
      SampleEdge = 1'b1;
      for (int i = 1; i <= 240; i++) begin
         tick();
         wcnt += int'(WordFlg);
         if (i == 19) begin
            check("t7_bit19", BitIdx, 19);
            check("t7_last19", LastBit, 1);
         end
         if (i == 20) check("t7_word1", WordIdx, 1);
         if (i == 220) check("t7_word11", WordIdx, 11);
         if (i == 239) check("t7_fflg239", FrameFlg, 0);
      end
      SampleEdge = 1'b0;
      check("t7_fflg240", FrameFlg, 1);
      check("t7_wcnt", wcnt, 12);
      check("t7_busy", Busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_spi_frame_counter

// File: doc/spi_frame_counter.md
SPI_FRAME_COUNTER -- requirements
Module: spi_frame_counter

Interface
REQ-001 SHALL have parameter MaxWordLen, default 32: largest supported bits per word (2..256).
REQ-002 SHALL have parameter MaxWords, default 16: largest supported words per frame (1..256).
REQ-003 SHALL derive local widths BW = clog2(MaxWordLen) and WW = max(1, clog2(MaxWords)).
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous reset, active low.
REQ-006 SHALL have port EnCount, input, 1 bit: run enable; low forces IDLE.
REQ-007 SHALL have port SampleEdge, input, 1 bit: one-cycle strobe marking one transferred bit.
REQ-008 SHALL have port Continuous, input, 1 bit: 1 restarts frames back-to-back; 0 stops after one frame.
REQ-009 SHALL have port WordLenM1, input, BW bits: bits per word minus one.
REQ-010 SHALL have port FrameLenM1, input, WW bits: words per frame minus one.
REQ-011 SHALL have port BitIdx, output, BW bits: index of the next bit to be sampled within the word.
REQ-012 SHALL have port WordIdx, output, WW bits: index of the current word within the frame.
REQ-013 SHALL have port LastBit, output, 1 bit: high while the next SampleEdge completes a word.
REQ-014 SHALL have port WordFlg, output, 1 bit: one-cycle pulse per completed word.
REQ-015 SHALL have port FrameFlg, output, 1 bit: one-cycle pulse per completed frame.
REQ-016 SHALL have port Busy, output, 1 bit: high in COUNT.

Function
REQ-017 SHALL implement states IDLE, COUNT and DONE.
REQ-018 SHALL transition IDLE->COUNT on the first cycle with EnCount=1, and latch WordLenM1 and FrameLenM1 on that edge; BitIdx and WordIdx SHALL be 0.
REQ-019 SHALL make COUNT ignore live WordLenM1 and FrameLenM1 changes; only the latched values apply.
REQ-020 SHALL, in COUNT, increment BitIdx on each SampleEdge; when BitIdx equals the latched WordLenM1, BitIdx SHALL wrap to 0 and WordFlg SHALL pulse on the next cycle (registered, one cycle).
REQ-021 SHALL, on a word completion, increment WordIdx; when WordIdx equals the latched FrameLenM1, WordIdx SHALL wrap to 0 and FrameFlg SHALL pulse in the same cycle as WordFlg.
REQ-022 SHALL, at frame completion with Continuous=1, stay in COUNT and relatch WordLenM1 and FrameLenM1 on that edge.
REQ-023 SHALL, at frame completion with Continuous=0, go to DONE; DONE SHALL ignore SampleEdge and hold BitIdx=0, WordIdx=0.
REQ-024 SHALL, in any state, go to IDLE, clear the counters and suppress WordFlg and FrameFlg on the next cycle when EnCount=0; this includes aborting mid-word.
REQ-025 SHALL require DONE to see EnCount=0 (IDLE) before a new frame starts.
REQ-026 SHALL make LastBit combinational: (state==COUNT) and (BitIdx==latched WordLenM1).
REQ-027 SHALL support WordLenM1=0 (1-bit word, LastBit constantly high in COUNT) and FrameLenM1=0 (every word ends a frame).
REQ-028 SHALL treat WordLenM1 >= MaxWordLen as MaxWordLen-1 when latched.
REQ-029 SHALL treat FrameLenM1 >= MaxWords as MaxWords-1 when latched.
REQ-030 SHALL ignore SampleEdge in the IDLE->COUNT entry cycle and count it from the next cycle on.

Reset
REQ-031 SHALL, on rst_n low, asynchronously force state IDLE, BitIdx=0, WordIdx=0, WordFlg=0, FrameFlg=0, Busy=0 and latched config=0.
REQ-032 SHALL resume on the first rising clk edge after rst_n deasserts, and behave as IDLE.

Structure
REQ-033 SHALL put the state encoding (IDLE=0, COUNT=1, DONE=2) in shared package spi_pkg.
REQ-034 SHALL be a single flat module with no sub-module; the clamp logic stays inline.

Verification
REQ-035 SHALL cover: WordLenM1=7, FrameLenM1=0, Continuous=0, 8 strobes -> one WordFlg and FrameFlg pulse in the cycle after strobe 8, then DONE and Busy=0.
REQ-036 SHALL cover: WordLenM1=3, FrameLenM1=2, Continuous=1, 24 strobes -> WordFlg after strobes 4,8,...,24 and FrameFlg after strobes 12 and 24.
REQ-037 SHALL cover: WordLenM1 changed from 7 to 3 mid-frame -> the current frame still uses 8-bit words and the next continuous frame uses 4-bit words.
REQ-038 SHALL cover: EnCount dropped after 5 of 8 strobes -> no WordFlg, next-cycle BitIdx=0, and a restart counts from 0.
REQ-039 SHALL cover: rst_n asserted mid-word, between clock edges -> outputs clear immediately without waiting for clk.
REQ-040 SHALL cover: WordLenM1=0 with strobes on consecutive cycles -> WordFlg high every cycle and LastBit constantly high.
